// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and limits for the bit-serial adder controller
package serial_adder_pkg;

    typedef enum logic [1:0] {
        SA_IDLE  = 2'd0,
        SA_SHIFT = 2'd1,
        SA_DONE  = 2'd2
    } sa_state_t;

    localparam int SA_WIDTH_MAX = 32;

endpackage

// File: rtl/serial_shift_reg.sv
// rtl/serial_shift_reg.sv - WIDTH-bit right-shift register, parallel load/out, serial in at MSB, serial out at LSB
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-low reset (clears contents)
//   i_load            parallel load of i_load_data (wins over i_shift)
//   i_load_data       parallel load value
//   i_shift           shift right one bit, i_serial entering at the MSB
//   i_serial          serial input bit
//   o_data            parallel contents
//   o_serial          LSB of the contents (the bit shifted out next)
module serial_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_data,
    input  logic             i_shift,
    input  logic             i_serial,
    output logic [WIDTH-1:0] o_data,
    output logic             o_serial
);

    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_shifted;

    generate
        if (WIDTH == 1) begin : g_one
            assign w_shifted = i_serial;
        end else begin : g_many
            assign w_shifted = {i_serial, r_data[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_load_data;
        end else if (i_shift) begin
            r_data <= w_shifted;
        end
    end

    assign o_data   = r_data;
    assign o_serial = r_data[0];

endmodule

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial addition controller driving an external single-bit full adder
//
// Optional build macro: SERIAL_ADDER_OV_EN (adds the registered signed-overflow flag; ov is 0 otherwise)
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-low reset
//   in_valid/in_ready          operand handshake; op_a, op_b, carry_in sampled on accept
//   fa_a0, fa_a1, fa_c0        to the full adder: current A bit, current B bit, registered carry
//   fa_s, fa_c1                from the full adder: sum bit and carry bit (same cycle)
//   out_valid/out_ready        result handshake; sum, carry_out, ov held while out_valid
//   busy                       operation in progress (SHIFT or DONE)
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             carry_in,
    output logic             fa_a0,
    output logic             fa_a1,
    output logic             fa_c0,
    input  logic             fa_s,
    input  logic             fa_c1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             ov,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    generate
        if (WIDTH < 1 || WIDTH > SA_WIDTH_MAX) begin : g_bad_width
            $error("serial_adder_ctrl: WIDTH out of range");
        end
    endgenerate

    sa_state_t        r_state;
    sa_state_t        w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry_out;

    logic             w_load;
    logic             w_shift;
    logic             w_last;
    logic             w_a_bit;
    logic             w_b_bit;
    logic [WIDTH-1:0] w_a_data;
    logic [WIDTH-1:0] w_b_data;
    logic [WIDTH-1:0] w_sum_data;
    logic             w_sum_lsb;
    logic [WIDTH-1:0] w_sum_next;
    logic             w_unused;

    // ------------------------------------------------------------------
    // Operand and sum shift registers
    // ------------------------------------------------------------------
    serial_shift_reg #(.WIDTH(WIDTH)) u_a_sr (
        .clk         (clk),
        .reset       (reset),
        .i_load      (w_load),
        .i_load_data (op_a),
        .i_shift     (w_shift),
        .i_serial    (1'b0),
        .o_data      (w_a_data),
        .o_serial    (w_a_bit)
    );

    serial_shift_reg #(.WIDTH(WIDTH)) u_b_sr (
        .clk         (clk),
        .reset       (reset),
        .i_load      (w_load),
        .i_load_data (op_b),
        .i_shift     (w_shift),
        .i_serial    (1'b0),
        .o_data      (w_b_data),
        .o_serial    (w_b_bit)
    );

    // Cleared at the start of each operation so no stale bits survive.
    serial_shift_reg #(.WIDTH(WIDTH)) u_sum_sr (
        .clk         (clk),
        .reset       (reset),
        .i_load      (w_load),
        .i_load_data ('0),
        .i_shift     (w_shift),
        .i_serial    (fa_s),
        .o_data      (w_sum_data),
        .o_serial    (w_sum_lsb)
    );

    // The sum shift register only completes on the same edge that enters
    // DONE, so the result register captures its next value directly.
    generate
        if (WIDTH == 1) begin : g_sum_one
            assign w_sum_next = fa_s;
        end else begin : g_sum_many
            assign w_sum_next = {fa_s, w_sum_data[WIDTH-1:1]};
        end
    endgenerate

    // Parallel views of A/B and the sum LSB are not needed by the controller.
    assign w_unused = ^{w_a_data, w_b_data, w_sum_data[0], w_sum_lsb};

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= SA_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        case (r_state)
            SA_IDLE: begin
                if (in_valid) begin
                    w_load       = 1'b1;
                    w_state_next = SA_SHIFT;
                end
            end
            SA_SHIFT: begin
                w_shift = 1'b1;
                if (w_last) begin
                    w_state_next = SA_DONE;
                end
            end
            SA_DONE: begin
                if (out_ready) begin
                    w_state_next = SA_IDLE;
                end
            end
            default: begin
                w_state_next = SA_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_sum       <= '0;
            r_carry_out <= 1'b0;
        end else if (w_load) begin
            r_cnt   <= '0;
            r_carry <= carry_in;
        end else if (w_shift) begin
            r_cnt   <= r_cnt + CNT_W'(1);
            r_carry <= fa_c1;
            if (w_last) begin
                r_sum       <= w_sum_next;
                r_carry_out <= fa_c1;
            end
        end
    end

`ifdef SERIAL_ADDER_OV_EN
    logic r_ov;

    // Signed overflow: carry into the MSB differs from carry out of it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ov <= 1'b0;
        end else if (w_shift && w_last) begin
            r_ov <= r_carry ^ fa_c1;
        end
    end

    assign ov = r_ov;
`else
    assign ov = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready  = (r_state == SA_IDLE);
    assign out_valid = (r_state == SA_DONE);
    assign busy      = (r_state == SA_SHIFT) || (r_state == SA_DONE);
    assign fa_a0     = (r_state == SA_SHIFT) && w_a_bit;
    assign fa_a1     = (r_state == SA_SHIFT) && w_b_bit;
    assign fa_c0     = (r_state == SA_SHIFT) && r_carry;
    assign sum       = r_sum;
    assign carry_out = r_carry_out;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - directed self-checking bench for serial_adder_ctrl (WIDTH=8 and WIDTH=1)
module tb_serial_adder_ctrl;

    logic       clk;
    logic       reset;

    // WIDTH=8 instance
    logic       in_valid, in_ready, carry_in;
    logic [7:0] op_a, op_b, sum;
    logic       fa_a0, fa_a1, fa_c0, fa_s, fa_c1;
    logic       out_valid, out_ready, carry_out, ov, busy;

    // WIDTH=1 instance
    logic       w1_in_valid, w1_in_ready, w1_carry_in;
    logic [0:0] w1_op_a, w1_op_b, w1_sum;
    logic       w1_fa_a0, w1_fa_a1, w1_fa_c0, w1_fa_s, w1_fa_c1;
    logic       w1_out_valid, w1_out_ready, w1_carry_out, w1_ov, w1_busy;

    int total = 0;
    int bad   = 0;

`ifdef SERIAL_ADDER_OV_EN
    localparam logic OV_ON = 1'b1;
`else
    localparam logic OV_ON = 1'b0;
`endif

    // External full adders
    assign fa_s     = fa_a0 ^ fa_a1 ^ fa_c0;
    assign fa_c1    = (fa_a0 & fa_a1) | (fa_a0 & fa_c0) | (fa_a1 & fa_c0);
    assign w1_fa_s  = w1_fa_a0 ^ w1_fa_a1 ^ w1_fa_c0;
    assign w1_fa_c1 = (w1_fa_a0 & w1_fa_a1) | (w1_fa_a0 & w1_fa_c0) | (w1_fa_a1 & w1_fa_c0);

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .carry_in  (carry_in),
        .fa_a0     (fa_a0),
        .fa_a1     (fa_a1),
        .fa_c0     (fa_c0),
        .fa_s      (fa_s),
        .fa_c1     (fa_c1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .ov        (ov),
        .busy      (busy)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut_w1 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (w1_in_valid),
        .in_ready  (w1_in_ready),
        .op_a      (w1_op_a),
        .op_b      (w1_op_b),
        .carry_in  (w1_carry_in),
        .fa_a0     (w1_fa_a0),
        .fa_a1     (w1_fa_a1),
        .fa_c0     (w1_fa_c0),
        .fa_s      (w1_fa_s),
        .fa_c1     (w1_fa_c1),
        .out_valid (w1_out_valid),
        .out_ready (w1_out_ready),
        .sum       (w1_sum),
        .carry_out (w1_carry_out),
        .ov        (w1_ov),
        .busy      (w1_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present operands, wait through accept, return cycles from accept to out_valid.
    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                            output int lat);
        op_a = a; op_b = b; carry_in = cin; in_valid = 1'b1;
        step();                       // accept edge; now in first SHIFT cycle
        in_valid = 1'b0;
        op_a = ~a; op_b = ~b; carry_in = ~cin;
        lat = 1;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
    endtask

    task automatic finish_op(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_ov_drop"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic [7:0] exp_sum,
                          input logic exp_c, input logic exp_ov);
        int lat;
        start_op(a, b, cin, lat);
        check({tag, "_latency"}, lat, 32'd9);
        check({tag, "_sum"}, {24'd0, sum}, {24'd0, exp_sum});
        check({tag, "_carry"}, {31'd0, carry_out}, {31'd0, exp_c});
        check({tag, "_ovf"}, {31'd0, ov}, {31'd0, exp_ov & OV_ON});
        finish_op(tag);
    endtask

    initial begin : main
        int lat;
        int pulses;
        logic [7:0] held_sum;
        logic       held_c;

        reset = 1'b0;
        in_valid = 1'b0; op_a = '0; op_b = '0; carry_in = 1'b0; out_ready = 1'b0;
        w1_in_valid = 1'b0; w1_op_a = '0; w1_op_b = '0; w1_carry_in = 1'b0; w1_out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // Reset state
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_sum", {24'd0, sum}, 32'd0);
        check("rst_carry", {31'd0, carry_out}, 32'd0);
        check("rst_ov", {31'd0, ov}, 32'd0);
        check("rst_fa", {29'd0, fa_a0, fa_a1, fa_c0}, 32'd0);

        // 0F + 01, with a look at the first SHIFT cycle
        op_a = 8'h0F; op_b = 8'h01; carry_in = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        op_a = 8'hF0; op_b = 8'hFE;
        check("shift1_fa", {29'd0, fa_a0, fa_a1, fa_c0}, 32'b110);
        check("shift1_busy", {31'd0, busy}, 32'd1);
        check("shift1_in_ready", {31'd0, in_ready}, 32'd0);
        check("shift1_sum_held", {24'd0, sum}, 32'd0);
        lat = 1;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
        check("op0f_latency", lat, 32'd9);
        check("op0f_sum", {24'd0, sum}, 32'h10);
        check("op0f_carry", {31'd0, carry_out}, 32'd0);
        check("op0f_ovf", {31'd0, ov}, 32'd0);
        check("op0f_fa_idle", {29'd0, fa_a0, fa_a1, fa_c0}, 32'd0);
        finish_op("op0f");

        run_op("opff", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op("op7f", 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1);
        run_op("op80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        run_op("opaa", 8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0);
        run_op("op3c", 8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0, 1'b1);

        // Backpressure: 12 + 34 + 1 = 47, held 5 cycles while new requests arrive
        start_op(8'h12, 8'h34, 1'b1, lat);
        check("bp_latency", lat, 32'd9);
        held_sum = sum;
        held_c   = carry_out;
        check("bp_sum", {24'd0, sum}, 32'h47);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; op_a = 8'hC3; op_b = 8'h3C;
            step();
            check("bp_sum_stable", {24'd0, sum}, {24'd0, held_sum});
            check("bp_carry_stable", {31'd0, carry_out}, {31'd0, held_c});
            check("bp_valid_held", {31'd0, out_valid}, 32'd1);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        finish_op("bp");
        check("bp_sum_after", {24'd0, sum}, 32'h47);
        check("bp_busy_after", {31'd0, busy}, 32'd0);

        // Reset during the 4th SHIFT cycle of AA + 55
        op_a = 8'hAA; op_b = 8'h55; carry_in = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (3) step();
        check("mid_busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("mid_in_ready", {31'd0, in_ready}, 32'd1);
        check("mid_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_sum", {24'd0, sum}, 32'd0);
        check("mid_fa", {29'd0, fa_a0, fa_a1, fa_c0}, 32'd0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (out_valid) pulses++;
        end
        check("mid_no_pulse", pulses, 32'd0);

        // WIDTH=1 build: 1 + 1 + 1 = 3
        w1_op_a = 1'b1; w1_op_b = 1'b1; w1_carry_in = 1'b1; w1_in_valid = 1'b1;
        step();
        w1_in_valid = 1'b0;
        check("w1_busy", {31'd0, w1_busy}, 32'd1);
        lat = 1;
        while (!w1_out_valid && lat < 40) begin
            step();
            lat++;
        end
        check("w1_latency", lat, 32'd2);
        check("w1_sum", {31'd0, w1_sum}, 32'd1);
        check("w1_carry", {31'd0, w1_carry_out}, 32'd1);
        check("w1_ovf", {31'd0, w1_ov}, 32'd0);
        w1_out_ready = 1'b1;
        step();
        w1_out_ready = 1'b0;
        check("w1_ov_drop", {31'd0, w1_out_valid}, 32'd0);
        check("w1_in_ready", {31'd0, w1_in_ready}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial addition controller that drives the team's single-bit full adder and consumes its outputs.
- Accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake.
- Presents one bit pair per cycle, LSB first, on fa_a0/fa_a1, with the registered carry on fa_c0.
- Collects fa_s/fa_c1 into a WIDTH-bit sum and carry-out, then offers the result on a valid/ready output.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 1..32.
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- in_valid  input  1  operand request.
- in_ready  output  1  controller can accept operands.
- op_a  input  WIDTH  addend A.
- op_b  input  WIDTH  addend B.
- carry_in  input  1  initial carry.
- fa_a0  output  1  to full adder a0: current bit of A.
- fa_a1  output  1  to full adder a1: current bit of B.
- fa_c0  output  1  to full adder c0: registered carry.
- fa_s  input  1  from full adder: sum bit (combinational in same cycle).
- fa_c1  input  1  from full adder: carry bit.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result sum.
- carry_out  output  1  final carry.
- ov  output  1  signed overflow flag (see Optional Feature).
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- Reset (reset==0 at a rising clk edge):
  - State goes to IDLE.
  - in_ready=1 on the cycle after reset; out_valid, busy, carry_out and ov are 0.
  - sum=0; the shift registers, bit counter and carry register are 0.
  - fa_a0=fa_a1=fa_c0=0.
  - Reset overrides all other inputs.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: load A_sr=op_a, B_sr=op_b, carry_reg=carry_in, cnt=0; go to SHIFT.
- SHIFT:
  - in_ready=0, busy=1.
  - fa_a0=A_sr[0], fa_a1=B_sr[0], fa_c0=carry_reg.
  - Every cycle: A_sr and B_sr shift right one bit; sum_sr shifts right with fa_s entering at the MSB; carry_reg<=fa_c1; cnt<=cnt+1.
  - When cnt==WIDTH-1 (last bit): go to DONE.
  - Exactly WIDTH SHIFT cycles per operation.
- DONE:
  - out_valid=1; sum=sum_sr; carry_out=carry_reg.
  - Outputs are held stable while out_ready=0 (backpressure, unbounded).
  - On out_valid&&out_ready: go to IDLE; out_valid drops on the next cycle.
- Latency: the handshake in cycle T gives out_valid=1 in cycle T+WIDTH+1.
- Throughput: one operation per WIDTH+2 cycles minimum. in_ready is never high in DONE, so there is no same-cycle result and operand turnover.
- fa_* outputs are 0 outside SHIFT.
- in_valid outside IDLE is ignored; op_* may change freely after acceptance.
- sum, carry_out and ov are registered and update only on entry to DONE. Outside DONE they hold the last result, or 0 after reset.
- Arithmetic: {carry_out,sum} = op_a + op_b + carry_in, modulo 2^(WIDTH+1).
- WIDTH=1: a single SHIFT cycle, with cnt comparing against 0.
- Reset asserted mid-SHIFT or mid-DONE: the operation is discarded, there is no out_valid pulse, and the block returns to IDLE.

Optional Feature:
- Macro: SERIAL_ADDER_OV_EN.
- Defined:
  - In the last SHIFT cycle, capture ov_next = carry_reg ^ fa_c1 (carry into MSB xor carry out of MSB).
  - Register ov alongside carry_out.
  - ov has the same stability and reset rules as sum.
- Undefined: ov is tied to constant 0 and no extra flops are inferred. The port list is identical in both builds.

Decomposition:
- Shared package serial_adder_pkg:
  - State enum type sa_state_t {SA_IDLE, SA_SHIFT, SA_DONE}, 2-bit encoding.
  - Constant SA_WIDTH_MAX=32.
- One natural sub-module, serial_shift_reg:
  - Parameterised WIDTH right-shift register.
  - Parallel load, parallel out, serial in at the MSB, serial out at the LSB, shift enable.
  - Instantiated three times: A, B, sum.
- The full adder itself stays external, connected in the bench/top via the fa_* ports.

Test Plan:
- WIDTH=8, op_a=8'h0F, op_b=8'h01, carry_in=0 -> sum=8'h10, carry_out=0, ov=0; out_valid first high exactly 9 cycles after the accept cycle.
- op_a=8'hFF, op_b=8'h01, carry_in=0 -> sum=8'h00, carry_out=1, ov=0.
- op_a=8'h7F, op_b=8'h00, carry_in=1 -> sum=8'h80, carry_out=0. ov=1 with SERIAL_ADDER_OV_EN, ov=0 without.
- Backpressure: out_ready held 0 for 5 cycles after out_valid -> sum/carry_out stable, in_ready=0, new in_valid ignored. One cycle after out_ready=1, out_valid=0 and in_ready=1.
- Reset mid-operation: reset=0 at the 4th SHIFT cycle of 8'hAA+8'h55 -> next cycle is IDLE with in_ready=1, out_valid=0, sum=0, fa_*=0; no out_valid pulse follows.
- WIDTH=1 build: op_a=1, op_b=1, carry_in=1 -> sum=1, carry_out=1; out_valid 2 cycles after the accept cycle.
